// File: rtl/dff.sv
// dff: WIDTH-bit D flip-flop with complementary outputs and an
// asynchronous active-low reset. Captures d_in on every rising clock edge.
// qb_out is derived from the same register as q_out, so the two can never
// disagree on any bit, in any cycle or during reset.
//
// Port names are fixed by the surrounding design (clock, reset, d_in,
// q_out, qb_out) and are kept as-is rather than renamed with _i/_o.
module dff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,   // active low, asynchronous
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qb_out
);

  // Next-state is simply the input; no enable, no set, no masking of X/Z.
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state selection: always load the data input on a capture edge.
  always_comb begin
    q_d = d_in;
  end

  // Storage: reset forces RST_VAL immediately, otherwise capture on rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Both outputs come from the single register; qb_out is its inverse.
  assign q_out  = q_q;
  assign qb_out = ~q_q;

endmodule

// File: tb/tb_dff.sv
// tb_dff: self-checking bench for dff. Two instances share one clock:
// a default 1-bit flop and an 8-bit flop with RST_VAL = 8'hA5.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// an edge or event. Expected values come from a behavioural model: the
// stored value is "last d seen at a rising edge while reset was high",
// or the reset value while reset is low.
`timescale 1ns/1ps
module tb_dff;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       d;
  logic       q, qb;
  logic       rst8_n;
  logic [7:0] d8, q8, qb8;

  int errors = 0;
  int checks = 0;

  // behavioural model of the stored 1-bit value
  logic exp_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dff u_dut (
    .clock  (clk),
    .reset  (rst_n),
    .d_in   (d),
    .q_out  (q),
    .qb_out (qb)
  );

  dff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clock  (clk),
    .reset  (rst8_n),
    .d_in   (d8),
    .q_out  (q8),
    .qb_out (qb8)
  );

  // Model update on every rising edge: reset wins, otherwise capture d.
  always @(posedge clk) begin
    if (rst_n === 1'b0) exp_q = 1'b0;
    else                exp_q = d;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got still running, required finished");
    errors = errors + 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic test_reset();
    // assert reset asynchronously, mid low phase, with d = 1
    rst_n = 1'b1;
    d     = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: q=%b qb=%b, required q=0 qb=1", q, qb);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== 1'b0 || qb !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold_rise%0d: q=%b qb=%b, required q=0 qb=1", i, q, qb);
      end
      @(negedge clk); #1;
      checks++;
      if (q !== 1'b0 || qb !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold_fall%0d: q=%b qb=%b, required q=0 qb=1", i, q, qb);
      end
    end
  endtask

  task automatic test_capture();
    logic pat [5];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d = pat[i];
      @(posedge clk); #1;
      checks++;
      if (q !== pat[i] || qb !== ~pat[i]) begin
        errors++;
        $display("FAIL capture%0d: q=%b qb=%b, required q=%b qb=%b", i, q, qb, pat[i], ~pat[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); d = 1'b1;
    @(posedge clk); #3;   // mid high phase, q should now be 1
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre: q=%b, required 1", q);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_async: q=%b qb=%b, required q=0 qb=1", q, qb);
    end
    @(negedge clk); rst_n = 1'b1; d = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_cap0: q=%b qb=%b, required q=0 qb=1", q, qb);
    end
    @(negedge clk); d = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_cap1: q=%b qb=%b, required q=1 qb=0", q, qb);
    end
  endtask

  task automatic test_coincident_reset();
    // q is 1; reset falls in the same timestep as a rising edge with d = 1
    @(negedge clk); d = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL coincident_reset: q=%b qb=%b, required q=0 qb=1", q, qb);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_hold();
    logic held;
    @(negedge clk); d = 1'b0;
    @(posedge clk); #1;
    held = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d = ~d;
      #1;
      checks++;
      if (q !== held || qb !== ~held) begin
        errors++;
        $display("FAIL hold_toggle%0d: q=%b qb=%b, required q=%b qb=%b", i, q, qb, held, ~held);
      end
    end
    d = 1'b1;   // last value before the edge
    @(posedge clk); #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      errors++;
      $display("FAIL hold_final: q=%b qb=%b, required q=1 qb=0", q, qb);
    end
  endtask

  task automatic test_random();
    // Sync model with the DUT's known state before starting.
    @(negedge clk); rst_n = 1'b1; d = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        exp_q = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      #1;
      checks++;
      if (q !== exp_q || qb !== ~q) begin
        errors++;
        $display("FAIL random_low%0d: q=%b qb=%b, required q=%b qb=%b", i, q, qb, exp_q, ~exp_q);
      end
      @(posedge clk);
      // occasional asynchronous reset pulse in the high phase
      if ($urandom_range(0, 15) == 0) begin
        #2;
        rst_n = 1'b0;
        exp_q = 1'b0;
        #1;
      end else begin
        #1;
      end
      checks++;
      if (q !== exp_q || qb !== ~q) begin
        errors++;
        $display("FAIL random_high%0d: q=%b qb=%b, required q=%b qb=%b", i, q, qb, exp_q, ~exp_q);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_params();
    @(negedge clk);
    d8     = 8'hFF;
    rst8_n = 1'b0;
    #1;
    checks++;
    if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
      errors++;
      $display("FAIL param_reset: q=%h qb=%h, required q=a5 qb=5a", q8, qb8);
    end
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'hA5 || qb8 !== 8'h5A) begin
      errors++;
      $display("FAIL param_reset_edge: q=%h qb=%h, required q=a5 qb=5a", q8, qb8);
    end
    @(negedge clk); rst8_n = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'h3C || qb8 !== 8'hC3) begin
      errors++;
      $display("FAIL param_capture: q=%h qb=%h, required q=3c qb=c3", q8, qb8);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n  = 1'b1;
    rst8_n = 1'b1;
    d      = 1'b0;
    d8     = 8'h00;
    exp_q  = 1'b0;
    test_reset();
    test_capture();
    test_mid_reset();
    test_coincident_reset();
    test_hold();
    test_random();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
